// File: rtl/mips32_mem_responder.sv
// Word-addressed memory responder with a configurable number of wait states.
// One request at a time; the access commits on the edge that enters RESP.
module mips32_mem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic [15:0] txn_count
);
  localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_reg;
  logic        we_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  cnt_reg;

  logic [31:0] mem [DEPTH];

  logic          acc_fire;
  logic          acc_we;
  logic          acc_in_range;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [31:0]   acc_rdata;
  logic [AW-1:0] acc_idx;

  // With zero wait states the access happens on the accept edge, so it must
  // use the live request fields instead of the latched copies.
  always_comb begin
    acc_we    = we_reg;
    acc_addr  = addr_reg;
    acc_wdata = wdata_reg;
    if (state_reg == S_IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end
  end

  assign acc_fire     = ((state_reg == S_IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                        ((state_reg == S_WAIT) && (cnt_reg == 4'd1));
  assign acc_in_range = (acc_addr < 32'(DEPTH));
  assign acc_idx      = acc_addr[AW-1:0];
  assign acc_rdata    = (!acc_we && acc_in_range) ? mem[acc_idx] : '0;

  assign req_ready = (state_reg == S_IDLE);
  assign busy      = (state_reg != S_IDLE);

  // Memory contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (acc_fire && acc_we && acc_in_range) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      cnt_reg   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      txn_count <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (req_valid) begin
            we_reg    <= req_we;
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
            cnt_reg   <= WAIT_INIT;
            if (WAIT_CYCLES == 0) begin
              state_reg <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= acc_rdata;
              rsp_err   <= !acc_in_range;
            end else begin
              state_reg <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_reg == 4'd1) begin
            state_reg <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= acc_rdata;
            rsp_err   <= !acc_in_range;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_reg <= S_IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            txn_count <= txn_count + 16'd1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mips32_mem_responder.sv
// Scoreboard bench for mips32_mem_responder: three instances with 1, 4 and 0
// wait states, covering write/read, range errors, backpressure, reset and wrap.
module tb_mips32_mem_responder;
  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst_n     [NI];
  logic        req_valid [NI];
  logic        req_ready [NI];
  logic        req_we    [NI];
  logic [31:0] req_addr  [NI];
  logic [31:0] req_wdata [NI];
  logic        rsp_valid [NI];
  logic        rsp_ready [NI];
  logic [31:0] rsp_rdata [NI];
  logic        rsp_err   [NI];
  logic        busy      [NI];
  logic [15:0] txn_count [NI];

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_dut
      mips32_mem_responder #(
        .DEPTH      (1024),
        .WAIT_CYCLES((gi == 0) ? 1 : ((gi == 1) ? 4 : 0))
      ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n[gi]),
        .req_valid(req_valid[gi]),
        .req_ready(req_ready[gi]),
        .req_we   (req_we[gi]),
        .req_addr (req_addr[gi]),
        .req_wdata(req_wdata[gi]),
        .rsp_valid(rsp_valid[gi]),
        .rsp_ready(rsp_ready[gi]),
        .rsp_rdata(rsp_rdata[gi]),
        .rsp_err  (rsp_err[gi]),
        .busy     (busy[gi]),
        .txn_count(txn_count[gi])
      );
    end
  endgenerate

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  bit   sb_on = 1'b1;
  int   cur = 0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wc_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 4 : 0);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Pops one expected response for every completed handshake.
  always @(negedge clk) begin
    if (sb_on && rsp_valid[cur] && rsp_ready[cur]) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_rsp", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("rsp_rdata", rsp_rdata[cur], mon_e.rdata);
        check("rsp_err", {31'b0, rsp_err[cur]}, {31'b0, mon_e.err});
        $display("txn inst%0d rdata=%h err=%0d (want %h/%0d) count_before=%0d",
                 cur, rsp_rdata[cur], rsp_err[cur], mon_e.rdata, mon_e.err, txn_count[cur]);
      end
    end
  end

  task automatic push_exp(input logic [31:0] rdata, input logic err);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    sb_q.push_back(e);
  endtask

  task automatic drive_req(input int i, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
    req_we[i]    = we;
    req_addr[i]  = addr;
    req_wdata[i] = wdata;
    req_valid[i] = 1'b1;
  endtask

  // Waits (bounded) for the request to be accepted; returns just after the edge.
  task automatic wait_accept(input int i);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready[i] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[i]) check("req_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_txn(input int i, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err);
    int lat;
    cur = i;
    rsp_ready[i] = 1'b1;
    push_exp(exp_rdata, exp_err);
    drive_req(i, we, addr, wdata);
    wait_accept(i);
    req_valid[i] = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid[i] && lat < 50);
    check("latency", 32'(lat), 32'(1 + wc_of(i)));
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input int i);
    check("rst_req_ready", {31'b0, req_ready[i]}, 32'd1);
    check("rst_rsp_valid", {31'b0, rsp_valid[i]}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata[i], 32'd0);
    check("rst_rsp_err", {31'b0, rsp_err[i]}, 32'd0);
    check("rst_busy", {31'b0, busy[i]}, 32'd0);
    check("rst_txn_count", {16'b0, txn_count[i]}, 32'd0);
  endtask

  initial begin
    logic [15:0] tc;
    int n;
    int prev_acc;
    bit timed_out;

    for (int i = 0; i < NI; i++) begin
      rst_n[i] = 1'b1; req_valid[i] = 1'b0; req_we[i] = 1'b0;
      req_addr[i] = '0; req_wdata[i] = '0; rsp_ready[i] = 1'b1;
    end
    #2;
    for (int i = 0; i < NI; i++) rst_n[i] = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) check_reset_vals(i);
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) rst_n[i] = 1'b1;
    @(posedge clk);
    #1;

    // Write then read, one wait state
    do_txn(0, 1'b1, 32'd5, 32'hDEADBEEF, 32'd0, 1'b0);
    do_txn(0, 1'b0, 32'd5, 32'd0, 32'hDEADBEEF, 1'b0);
    check("wr_rd_txn_count", {16'b0, txn_count[0]}, 32'd2);

    // Out-of-range accesses must not alias onto low addresses
    do_txn(0, 1'b1, 32'd0, 32'h0BADF00D, 32'd0, 1'b0);
    do_txn(0, 1'b1, 32'd1024, 32'h00001234, 32'd0, 1'b1);
    do_txn(0, 1'b0, 32'd1024, 32'd0, 32'd0, 1'b1);
    do_txn(0, 1'b0, 32'h80000000, 32'd0, 32'd0, 1'b1);
    do_txn(0, 1'b0, 32'd0, 32'd0, 32'h0BADF00D, 1'b0);
    do_txn(0, 1'b0, 32'd1023, 32'd0, 32'd0, 1'b0);
    check("oor_txn_count", {16'b0, txn_count[0]}, 32'd8);

    // Backpressure: response held, intruding request ignored
    do_txn(0, 1'b1, 32'd3, 32'hA5A5A5A5, 32'd0, 1'b0);
    cur = 0;
    rsp_ready[0] = 1'b0;
    push_exp(32'hA5A5A5A5, 1'b0);
    drive_req(0, 1'b0, 32'd3, 32'd0);
    wait_accept(0);
    req_valid[0] = 1'b0;
    n = 0;
    @(negedge clk);
    while (!rsp_valid[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    drive_req(0, 1'b1, 32'd3, 32'h00000000);
    for (int k = 0; k < 6; k++) begin
      check("bp_rsp_valid", {31'b0, rsp_valid[0]}, 32'd1);
      check("bp_rsp_rdata", rsp_rdata[0], 32'hA5A5A5A5);
      check("bp_req_ready", {31'b0, req_ready[0]}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    tc = txn_count[0];
    rsp_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    check("bp_one_handshake", {16'b0, txn_count[0]}, {16'b0, tc + 16'd1});
    check("bp_rsp_valid_low", {31'b0, rsp_valid[0]}, 32'd0);
    @(posedge clk);
    #1;
    check("bp_no_extra", {16'b0, txn_count[0]}, {16'b0, tc + 16'd1});
    do_txn(0, 1'b0, 32'd3, 32'd0, 32'hA5A5A5A5, 1'b0);

    // Reset during WAIT drops the pending write
    do_txn(1, 1'b1, 32'd7, 32'h11111111, 32'd0, 1'b0);
    cur = 1;
    drive_req(1, 1'b1, 32'd7, 32'hFFFFFFFF);
    wait_accept(1);
    req_valid[1] = 1'b0;
    repeat (2) @(negedge clk);
    check("rw_busy_in_wait", {31'b0, busy[1]}, 32'd1);
    #1;
    rst_n[1] = 1'b0;
    #1;
    check_reset_vals(1);
    @(negedge clk);
    rst_n[1] = 1'b1;
    @(posedge clk);
    #1;
    do_txn(1, 1'b0, 32'd7, 32'd0, 32'h11111111, 1'b0);
    check("rw_txn_count", {16'b0, txn_count[1]}, 32'd1);

    // Zero wait states: back-to-back reads with req_valid held high
    for (int k = 0; k < 4; k++) do_txn(2, 1'b1, 32'(k), 32'h10000000 + 32'(k), 32'd0, 1'b0);
    cur = 2;
    rsp_ready[2] = 1'b1;
    prev_acc = 0;
    drive_req(2, 1'b0, 32'd0, 32'd0);
    for (int k = 0; k < 8; k++) begin
      req_addr[2] = 32'(k % 4);
      push_exp(32'h10000000 + 32'(k % 4), 1'b0);
      wait_accept(2);
      if (k > 0) check("zw_spacing", 32'(cyc - prev_acc), 32'd2);
      prev_acc = cyc;
      @(negedge clk);
      check("zw_rsp_latency", {31'b0, rsp_valid[2]}, 32'd1);
    end
    req_valid[2] = 1'b0;
    @(posedge clk);
    #1;
    check("zw_txn_count", {16'b0, txn_count[2]}, 32'd12);

    // Counter wrap on the zero-wait instance
    rst_n[2] = 1'b0;
    #1;
    check("wrap_start", {16'b0, txn_count[2]}, 32'd0);
    @(negedge clk);
    rst_n[2] = 1'b1;
    @(posedge clk);
    #1;
    sb_on = 1'b0;
    timed_out = 1'b0;
    drive_req(2, 1'b0, 32'd0, 32'd0);
    for (int i = 1; i <= 65537 && !timed_out; i++) begin
      wait_accept(2);
      if (i == 65537) req_valid[2] = 1'b0;
      n = 0;
      @(negedge clk);
      while (!rsp_valid[2] && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (!rsp_valid[2]) begin
        check("wrap_rsp_timeout", 32'd0, 32'd1);
        timed_out = 1'b1;
      end
      @(posedge clk);
      #1;
      if (i == 1 || i == 65535 || i == 65536 || i == 65537)
        check("wrap_txn_count", {16'b0, txn_count[2]}, {16'b0, 16'(i)});
    end
    req_valid[2] = 1'b0;
    sb_on = 1'b1;

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
